// File: rtl/envelope_shaper.sv
// envelope_shaper: ADSR amplitude envelope between the NCO and the PWM output.
// A gate-driven FSM moves a 16-bit envelope through attack/decay/sustain/release.
// A two-stage pipeline scales the sample's deviation from midscale by env[15:8].
module envelope_shaper #(
    parameter int CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       gate,
    input  logic [7:0] sample_in,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] value_out,
    output logic [7:0] env_level,
    output logic       active
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic              gate_meta;
    logic              gate_s;
    logic [CNT_W-1:0]  pre_cnt;
    logic              tick;
    logic [2:0]        state;
    logic [15:0]       env;

    logic [15:0]       attack_step;
    logic [15:0]       decay_step;
    logic [15:0]       release_step;
    logic [15:0]       s16;
    logic [16:0]       attack_sum;
    logic [16:0]       decay_floor;

    logic signed [8:0] s_p1;
    logic [7:0]        e_p1;
    logic [7:0]        value_p2;
    logic              active_r;

    // Scale a signed deviation by an unsigned envelope byte and re-centre on 128.
    // The shift floors toward minus infinity, so the result stays within 0..254.
    function automatic logic [7:0] scale_sample(input logic signed [8:0] s,
                                                input logic [7:0] e);
        logic signed [17:0] s_x;
        logic signed [17:0] e_x;
        logic signed [17:0] prod;
        logic signed [9:0]  shifted;
        s_x     = {{9{s[8]}}, s};
        e_x     = {10'd0, e};
        prod    = s_x * e_x;
        shifted = 10'(prod >>> 8);
        return 8'(shifted + 10'sd128);
    endfunction

    assign attack_step  = {8'h00, attack_rate};
    assign decay_step   = {8'h00, decay_rate};
    assign release_step = {8'h00, release_rate};
    assign s16          = {sustain_level, 8'h00};
    // Widened sums so saturation and the decay floor compare without wrap-around.
    assign attack_sum   = {1'b0, env} + {1'b0, attack_step};
    assign decay_floor  = {1'b0, s16} + {1'b0, decay_step};
    assign tick         = (pre_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous gate level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_meta <= 1'b0;
            gate_s    <= 1'b0;
        end else begin
            gate_meta <= gate;
            gate_s    <= gate_meta;
        end
    end

    // Free-running prescaler producing a one-cycle envelope tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CNT_W'(1);
        end
    end

    // ADSR state machine; gate transitions take priority over tick-driven steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            env   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gate_s) state <= ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (!gate_s) begin
                        state <= ST_RELEASE;
                    end else if (tick) begin
                        if (attack_rate == 8'd0 || attack_sum >= 17'h0FFFF) begin
                            env   <= 16'hFFFF;
                            state <= ST_DECAY;
                        end else begin
                            env <= attack_sum[15:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (!gate_s) begin
                        state <= ST_RELEASE;
                    end else if (tick) begin
                        // env - step <= S16 rewritten as env <= S16 + step to avoid underflow.
                        if (decay_rate == 8'd0 || {1'b0, env} <= decay_floor) begin
                            env   <= s16;
                            state <= ST_SUSTAIN;
                        end else begin
                            env <= env - decay_step;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate_s) begin
                        state <= ST_RELEASE;
                    end else begin
                        env <= s16;
                    end
                end
                ST_RELEASE: begin
                    if (gate_s) begin
                        state <= ST_ATTACK;
                    end else if (tick) begin
                        if (release_rate == 8'd0 || env <= release_step) begin
                            env   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            env <= env - release_step;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    env   <= '0;
                end
            endcase
        end
    end

    // Stage 1: centre the sample and capture the envelope byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_p1 <= '0;
            e_p1 <= '0;
        end else begin
            s_p1 <= $signed({1'b0, sample_in}) - 9'sd128;
            e_p1 <= env[15:8];
        end
    end

    // Stage 2: scaled output back in offset-binary form.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_p2 <= 8'd128;
        end else begin
            value_p2 <= scale_sample(s_p1, e_p1);
        end
    end

    // Registered activity flag, one cycle behind the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_r <= 1'b0;
        end else begin
            active_r <= (state != ST_IDLE);
        end
    end

    assign value_out = value_p2;
    assign env_level = e_p1;
    assign active    = active_r;

endmodule

// File: tb/tb_envelope_shaper.sv
// Testbench for envelope_shaper: directed phases with random samples and rates,
// checked against a cycle-level behavioural model of the envelope rules.
module tb_envelope_shaper;

    localparam int CLK_DIV = 4;

    localparam int PH_IDLE    = 0;
    localparam int PH_ATTACK  = 1;
    localparam int PH_DECAY   = 2;
    localparam int PH_SUSTAIN = 3;
    localparam int PH_RELEASE = 4;

    logic       clk;
    logic       reset_n;
    logic       gate;
    logic [7:0] sample_in;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] value_out;
    logic [7:0] env_level;
    logic       active;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        int   pre;
        logic g0;
        logic g1;
        int   ph;
        int   env;
        int   s1;
        int   e1;
        int   vout;
        logic act;
    } model_t;

    model_t m;

    envelope_shaper #(.CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .gate          (gate),
        .sample_in     (sample_in),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .value_out     (value_out),
        .env_level     (env_level),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div256(input int p);
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.pre  = 0;
        r.g0   = 1'b0;
        r.g1   = 1'b0;
        r.ph   = PH_IDLE;
        r.env  = 0;
        r.s1   = 0;
        r.e1   = 0;
        r.vout = 128;
        r.act  = 1'b0;
        return r;
    endfunction

    // One clock of the envelope rules, expressed with plain integer arithmetic.
    function automatic model_t next_model(input model_t c, input logic g,
                                          input logic [7:0] smp, input logic [7:0] ar,
                                          input logic [7:0] dr, input logic [7:0] sl,
                                          input logic [7:0] rr);
        model_t n;
        bit     tick;
        bit     gs;
        int     sus;
        n    = c;
        tick = (c.pre == CLK_DIV - 1);
        gs   = c.g1;
        sus  = int'(sl) * 256;
        n.pre = (c.pre + 1) % CLK_DIV;
        n.g0  = g;
        n.g1  = c.g0;
        case (c.ph)
            PH_IDLE: if (gs) n.ph = PH_ATTACK;
            PH_ATTACK: begin
                if (!gs) n.ph = PH_RELEASE;
                else if (tick) begin
                    if (ar == 0) n.env = 65535;
                    else n.env = (c.env + int'(ar) > 65535) ? 65535 : c.env + int'(ar);
                    if (n.env == 65535) n.ph = PH_DECAY;
                end
            end
            PH_DECAY: begin
                if (!gs) n.ph = PH_RELEASE;
                else if (tick) begin
                    if (dr == 0 || c.env - int'(dr) <= sus) begin
                        n.env = sus;
                        n.ph  = PH_SUSTAIN;
                    end else n.env = c.env - int'(dr);
                end
            end
            PH_SUSTAIN: begin
                if (!gs) n.ph = PH_RELEASE;
                else n.env = sus;
            end
            default: begin
                if (gs) n.ph = PH_ATTACK;
                else if (tick) begin
                    if (rr == 0 || c.env <= int'(rr)) begin
                        n.env = 0;
                        n.ph  = PH_IDLE;
                    end else n.env = c.env - int'(rr);
                end
            end
        endcase
        n.s1   = int'(smp) - 128;
        n.e1   = c.env / 256;
        n.vout = 128 + floor_div256(c.s1 * c.e1);
        n.act  = (c.ph != PH_IDLE);
        return n;
    endfunction

    // Reference model state, advanced alongside the design.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else m <= next_model(m, gate, sample_in, attack_rate, decay_rate,
                             sustain_level, release_rate);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("model_value_out", 32'(value_out), m.vout);
        chk("model_env_level", 32'(env_level), m.e1);
        chk("model_active", 32'(active), 32'(m.act));
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_model();
            if (rnd) sample_in = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        bit         found;
        logic [7:0] prev;
        reset_n       = 1'b0;
        gate          = 1'b0;
        sample_in     = 8'd128;
        attack_rate   = 8'd255;
        decay_rate    = 8'd16;
        sustain_level = 8'h80;
        release_rate  = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_value_out", 32'(value_out), 128);
        chk("reset_env_level", 32'(env_level), 0);
        chk("reset_active", 32'(active), 0);
        check_model();
        reset_n = 1'b1;
        run(5, 1);

        // Attack entry and peak
        gate = 1'b1;
        run(3, 1);
        chk("attack_entry_pre", 32'(active), 0);
        run(1, 1);
        chk("attack_entry", 32'(active), 1);
        run(1041, 1);
        chk("attack_peak", 32'(env_level), 32'hFF);

        // Decay to sustain, then live sustain change
        run(9000, 1);
        chk("sustain_80", 32'(env_level), 32'h80);
        chk("sustain_active", 32'(active), 1);
        sustain_level = 8'h40;
        run(2, 1);
        chk("sustain_40", 32'(env_level), 32'h40);

        // Instant release
        gate         = 1'b0;
        release_rate = 8'd0;
        run(12, 1);
        chk("release_instant_env", 32'(env_level), 0);
        chk("release_instant_idle", 32'(active), 0);

        // Scaling with env = 0
        sample_in = 8'd255;
        run(2, 0);
        chk("silent_255", 32'(value_out), 128);
        sample_in = 8'd0;
        run(2, 0);
        chk("silent_0", 32'(value_out), 128);

        // Full-scale envelope via instant attack and sustain 255
        attack_rate   = 8'd0;
        sustain_level = 8'hFF;
        gate          = 1'b1;
        run(24, 1);
        chk("full_env", 32'(env_level), 32'hFF);
        sample_in = 8'd128;
        run(2, 0);
        sample_in = 8'd255;
        run(1, 0);
        chk("scale_latency", 32'(value_out), 128);
        run(1, 0);
        chk("scale_255", 32'(value_out), 254);
        sample_in = 8'd0;
        run(2, 0);
        chk("scale_0", 32'(value_out), 0);
        sample_in = 8'd128;
        run(2, 0);
        chk("scale_128", 32'(value_out), 128);

        // Slow release then retrigger from about 0x3000
        release_rate = 8'd64;
        gate         = 1'b0;
        found        = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            run(1, 1);
            if (env_level == 8'h30) begin
                found = 1'b1;
                break;
            end
        end
        chk("release_reach_30", 32'(found), 1);
        attack_rate = 8'd1;
        gate        = 1'b1;
        run(40, 1);
        chk("retrigger_level", 32'(env_level), 32'h30);
        chk("retrigger_active", 32'(active), 1);

        // Gate drop mid-attack at about 0x2000
        gate         = 1'b0;
        release_rate = 8'd0;
        run(12, 1);
        chk("idle_again", 32'(active), 0);
        attack_rate = 8'd32;
        gate        = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            run(1, 1);
            if (env_level == 8'h20) begin
                found = 1'b1;
                break;
            end
        end
        chk("attack_reach_20", 32'(found), 1);
        gate         = 1'b0;
        release_rate = 8'd16;
        prev         = env_level;
        found        = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            run(1, 1);
            chk("release_monotonic", 32'(env_level <= prev), 1);
            prev = env_level;
            if (!active) begin
                found = 1'b1;
                break;
            end
        end
        chk("release_done", 32'(found), 1);
        chk("release_floor", 32'(env_level), 0);

        // Random rates, sustain and gate activity
        for (int it = 0; it < 4; it++) begin
            attack_rate   = 8'($urandom_range(0, 255));
            decay_rate    = 8'($urandom_range(0, 255));
            sustain_level = 8'($urandom_range(0, 255));
            release_rate  = 8'($urandom_range(0, 255));
            gate          = 1'($urandom_range(0, 1));
            run(150, 1);
            gate = ~gate;
            run(150, 1);
        end

        // Reset in the middle of an attack at about 0x4000
        gate         = 1'b0;
        release_rate = 8'd0;
        run(12, 1);
        attack_rate = 8'd255;
        decay_rate  = 8'd16;
        gate        = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            run(1, 1);
            if (env_level == 8'h40) begin
                found = 1'b1;
                break;
            end
        end
        chk("attack_reach_40", 32'(found), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_value_out", 32'(value_out), 128);
        chk("midreset_env_level", 32'(env_level), 0);
        chk("midreset_active", 32'(active), 0);
        gate = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run(10, 1);
        chk("post_reset_idle", 32'(active), 0);
        chk("post_reset_env", 32'(env_level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
